mode_sequencer: RTL and testbench
=================================

// Module: mode_sequencer
// PURPOSE
//  Initiator side of the mode/status interface served by the control FSM.
//  - Accepts mode-change requests over a valid/ready handshake.
//  - Drives mode_out to the responder, then checks that status_in matches for SETTLE_CYCLES consecutive cycles.
//  - Reports completion (done) or failure (err + err_code).
//  - Sits between the host/config logic and the control FSM.
// PARAMETERS
//  SETTLE_CYCLES   2  consecutive matching status samples needed to declare done (>=1)
//  TIMEOUT_CYCLES  8  WAIT-state edges allowed before a timeout error (> SETTLE_CYCLES)
//  CNT_W           4  width of the internal timer and match counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  rst        in   1  synchronous reset, active-low
//  req_valid  in   1  host presents a mode request
//  req_mode   in   2  requested mode: 00 idle, 01 mode A, 10 mode B, 11 illegal
//  req_ready  out  1  sequencer can accept a request (high only in IDLE)
//  abort      in   1  cancels an in-flight request (sampled in WAIT only)
//  mode_out   out  2  mode driven to the responder; registered
//  status_in  in   2  status returned by the responder
//  busy       out  1  high while in WAIT
//  done       out  1  one-cycle pulse: requested mode confirmed
//  err        out  1  one-cycle pulse: request failed
//  err_code   out  2  00 none, 01 ILLEGAL, 10 TIMEOUT, 11 ABORT; held until the next err or reset
//  cur_mode   out  2  last confirmed mode
// BEHAVIOUR
//  Reset: any rising edge with rst=0 does the following.
//   - state=IDLE; mode_out=00; cur_mode=00; err_code=00.
//   - done=0; err=0; busy=0; timer and match counter cleared.
//   - req_ready is forced 0 while rst=0, and is 1 in the first cycle after rst returns high.
//  Reset mid-WAIT aborts silently: no done, no err.
//  Expected status equals mode_out (00->00, 01->01, 10->10).
//  States: IDLE, WAIT. done and err are registered pulses, never both high in one cycle.
//  IDLE
//   - Handshake: a request is accepted on an edge where req_valid && req_ready.
//     req_mode must be held stable while req_valid is high and not yet accepted.
//   - req_mode=11 on accept: err=1 for one cycle, err_code=01; state stays IDLE; mode_out and cur_mode unchanged.
//   - Legal req_mode on accept: mode_out<=req_mode; timer=0; match=0; state->WAIT; busy=1.
//  WAIT, evaluated each edge
//   - Match counter: status_in==mode_out increments match (saturating); any mismatch resets match to 0.
//   - Settle: when match reaches SETTLE_CYCLES: done=1 for one cycle, cur_mode<=mode_out, state->IDLE.
//     req_ready rises in the same cycle as done.
//   - Timeout: otherwise timer increments. When timer reaches TIMEOUT_CYCLES:
//     err=1, err_code=10, mode_out<=00 (safe), cur_mode<=00, state->IDLE.
//   - Abort: mode_out<=00, cur_mode<=00, err=1, err_code=11, state->IDLE.
//   - Priority on the same edge: reset > settle > abort > timeout.
//  Latency with a combinational responder: done is high in the cycle following the SETTLE_CYCLES-th edge after the accept edge.
//  req_valid in WAIT is ignored; it is not queued.
// STRUCTURE
//  Shared package mode_pkg holds:
//   - MODE_IDLE=2'b00, MODE_A=2'b01, MODE_B=2'b10, MODE_ILLEGAL=2'b11
//   - ERR_NONE/ILLEGAL/TIMEOUT/ABORT codes
//   - state encodings ST_IDLE/ST_WAIT
//  Sub-module settle_timer (CNT_W, SETTLE_CYCLES, TIMEOUT_CYCLES).
//   - Contains the match counter and timeout counter.
//   - Inputs: clear, enable, match. Outputs: settled, timed_out.
// TESTING (SETTLE_CYCLES=2, TIMEOUT_CYCLES=8; responder model: status_in=mode_out combinationally unless stated)
//  1 Reset: rst=0 for 2 cycles.
//    -> mode_out=00, cur_mode=00, done=err=busy=0, req_ready=0; req_ready=1 in the first cycle after release.
//  2 Request 01 accepted at edge E0.
//    -> mode_out=01 after E0; busy=1; done=1 only in the cycle after E2; cur_mode=01; req_ready=1 in that cycle.
//  3 Request 11.
//    -> err=1 one cycle, err_code=01, mode_out and cur_mode unchanged, no done, state stays IDLE.
//  4 Responder stuck at status_in=00, request 10.
//    -> no done; err=1 after the 8th WAIT edge, err_code=10, mode_out=00, cur_mode=00.
//  5 status_in glitch pattern match, mismatch, match, match after accepting 01.
//    -> done only after the 4th WAIT edge.
//    -> abort=1 on the 1st WAIT edge instead gives err_code=11, mode_out=00.
//  6 rst=0 on the 1st WAIT edge of a request 10.
//    -> next cycle state IDLE, mode_out=00, cur_mode=00, done=err=0; no later pulse.

Source files
------------

// File: rtl/mode_pkg.sv
// Shared definitions for the mode sequencer.
// Mode values, error codes and FSM state encoding.
package mode_pkg;

    localparam logic [1:0] MODE_IDLE    = 2'b00;
    localparam logic [1:0] MODE_A       = 2'b01;
    localparam logic [1:0] MODE_B       = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/mode_sequencer_settle_timer.sv
// Match counter and timeout counter for the WAIT state.
// settled/timed_out look one edge ahead so the FSM acts on that edge.
module settle_timer #(
    parameter int CNT_W          = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic match,
    output logic settled,
    output logic timed_out
);

    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] TMO_C    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] match_q, match_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] match_inc, timer_inc;

    // Saturating increments and the next-edge settle/timeout decisions
    always_comb begin
        match_inc = (&match_q) ? match_q : match_q + ONE;
        timer_inc = (&timer_q) ? timer_q : timer_q + ONE;
        settled   = enable && match && (match_inc >= SETTLE_C);
        timed_out = enable && (timer_inc >= TMO_C);
        match_d   = match_q;
        timer_d   = timer_q;
        if (clear) begin
            match_d = '0;
            timer_d = '0;
        end else if (enable) begin
            match_d = match ? match_inc : '0;
            timer_d = timer_inc;
        end
    end

    // Counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            match_q <= '0;
            timer_q <= '0;
        end else begin
            match_q <= match_d;
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Initiator of the mode/status interface: drives a mode,
// waits for matching status, reports done or err.
module mode_sequencer
    import mode_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 8,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_mode,
    output logic       req_ready,
    input  logic       abort,
    output logic [1:0] mode_out,
    input  logic [1:0] status_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [1:0] cur_mode
);

    state_e     state_q, state_d;
    logic [1:0] mode_q, mode_d;
    logic [1:0] cur_q, cur_d;
    logic [1:0] code_q, code_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic clear_cnt;
    logic in_wait;
    logic settled;
    logic timed_out;

    assign in_wait   = (state_q == ST_WAIT);
    assign clear_cnt = !in_wait && req_valid && (req_mode != MODE_ILLEGAL);

    settle_timer #(
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_cnt),
        .enable   (in_wait),
        .match    (status_in == mode_q),
        .settled  (settled),
        .timed_out(timed_out)
    );

    // Next state and outputs; settle beats abort beats timeout
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cur_d   = cur_q;
        code_d  = code_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_mode == MODE_ILLEGAL) begin
                        err_d  = 1'b1;
                        code_d = ERR_ILLEGAL;
                    end else begin
                        mode_d  = req_mode;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (settled) begin
                    done_d  = 1'b1;
                    cur_d   = mode_q;
                    state_d = ST_IDLE;
                end else if (abort) begin
                    err_d   = 1'b1;
                    code_d  = ERR_ABORT;
                    mode_d  = MODE_IDLE;
                    cur_d   = MODE_IDLE;
                    state_d = ST_IDLE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    mode_d  = MODE_IDLE;
                    cur_d   = MODE_IDLE;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State register; reset also cancels any in-flight request silently
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_IDLE;
            cur_q   <= MODE_IDLE;
            code_q  <= ERR_NONE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cur_q   <= cur_d;
            code_q  <= code_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = rst && !in_wait;
    assign busy      = in_wait;
    assign mode_out  = mode_q;
    assign cur_mode  = cur_q;
    assign err_code  = code_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Testbench for mode_sequencer: directed vector table
// followed by randomized traffic against a reference model.
module tb_mode_sequencer;

    localparam int S = 2;
    localparam int T = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_mode = 2'b00;
    logic       req_ready;
    logic       abort = 1'b0;
    logic [1:0] mode_out;
    logic [1:0] status_in;
    logic       busy, done, err;
    logic [1:0] err_code;
    logic [1:0] cur_mode;

    logic       stuck_en = 1'b0;
    logic [1:0] stuck_val = 2'b00;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign status_in = stuck_en ? stuck_val : mode_out;

    mode_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_mode (req_mode),
        .req_ready(req_ready),
        .abort    (abort),
        .mode_out (mode_out),
        .status_in(status_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .cur_mode (cur_mode)
    );

    // Reference model: a request in flight, its mode, a run length
    // of consecutive matching samples and a count of waited edges.
    bit       m_inflight;
    bit [1:0] m_drive, m_cur, m_code;
    bit       m_done, m_err;
    int       m_run, m_edges;

    function automatic void model_edge(bit r, bit v, bit [1:0] md,
                                       bit ab, bit [1:0] st);
        m_done = 0;
        m_err  = 0;
        if (!r) begin
            m_inflight = 0;
            m_drive = 0;
            m_cur = 0;
            m_code = 0;
            m_run = 0;
            m_edges = 0;
        end else if (!m_inflight) begin
            if (v && md == 3) begin
                m_err = 1;
                m_code = 1;
            end else if (v) begin
                m_drive = md;
                m_inflight = 1;
                m_run = 0;
                m_edges = 0;
            end
        end else begin
            m_edges++;
            m_run = (st == m_drive) ? m_run + 1 : 0;
            if (m_run >= S) begin
                m_done = 1;
                m_cur = m_drive;
                m_inflight = 0;
            end else if (ab || m_edges >= T) begin
                m_err = 1;
                m_code = ab ? 2'd3 : 2'd2;
                m_drive = 0;
                m_cur = 0;
                m_inflight = 0;
            end
        end
    endfunction

    // Apply inputs, clock one edge, advance the model, settle #1
    task automatic step(bit r, bit v, bit [1:0] md, bit ab,
                        bit se, bit [1:0] sv);
        bit [1:0] st;
        rst = r;
        req_valid = v;
        req_mode = md;
        abort = ab;
        stuck_en = se;
        stuck_val = sv;
        st = se ? sv : m_drive;
        @(posedge clk);
        model_edge(r, v, md, ab, st);
        #1;
    endtask

    function automatic bit [9:0] dut_vec();
        return {mode_out, cur_mode, busy, done, err, err_code, req_ready};
    endfunction

    task automatic check(string name, bit [9:0] exp);
        tests++;
        if (dut_vec() !== exp) begin
            fails++;
            $display("FAIL %s: got mo/cur/busy/done/err/code/rdy=%b want %b",
                     name, dut_vec(), exp);
        end
    endtask

    typedef struct {
        string    name;
        bit       r, v, ab, se;
        bit [1:0] md, sv;
        bit [1:0] mo, cur;
        bit       bsy, dn, er;
        bit [1:0] code;
        bit       rdy;
    } vec_t;

    vec_t vt[$];

    function automatic void add(string n, bit r, bit v, bit [1:0] md,
                                bit ab, bit se, bit [1:0] sv,
                                bit [1:0] mo, bit [1:0] cur, bit bsy,
                                bit dn, bit er, bit [1:0] code, bit rdy);
        vec_t e;
        e.name = n; e.r = r; e.v = v; e.md = md; e.ab = ab;
        e.se = se; e.sv = sv; e.mo = mo; e.cur = cur; e.bsy = bsy;
        e.dn = dn; e.er = er; e.code = code; e.rdy = rdy;
        vt.push_back(e);
    endfunction

    initial begin
        //   name        r v md ab se sv  mo cur b d e code rdy
        add("rst0",      0,0,0, 0,0,0,    0, 0, 0,0,0,0,   0);
        add("rst1",      0,0,0, 0,0,0,    0, 0, 0,0,0,0,   0);
        add("release",   1,0,0, 0,0,0,    0, 0, 0,0,0,0,   1);
        add("reqA_E0",   1,1,1, 0,0,0,    1, 0, 1,0,0,0,   0);
        add("reqA_E1",   1,1,2, 0,0,0,    1, 0, 1,0,0,0,   0);
        add("reqA_E2",   1,0,0, 0,0,0,    1, 1, 0,1,0,0,   1);
        add("reqA_post", 1,0,0, 0,0,0,    1, 1, 0,0,0,0,   1);
        add("illegal",   1,1,3, 0,0,0,    1, 1, 0,0,1,1,   1);
        add("ill_post",  1,0,0, 0,0,0,    1, 1, 0,0,0,1,   1);
        add("tmo_acc",   1,1,2, 0,1,0,    2, 1, 1,0,0,1,   0);
        for (int i = 1; i < T; i++)
            add("tmo_wait",  1,0,0, 0,1,0, 2, 1, 1,0,0,1, 0);
        add("tmo_fire",  1,0,0, 0,1,0,    0, 0, 0,0,1,2,   1);
        add("tmo_post",  1,0,0, 0,0,0,    0, 0, 0,0,0,2,   1);
        add("gl_acc",    1,1,1, 0,0,0,    1, 0, 1,0,0,2,   0);
        add("gl_w1",     1,0,0, 0,0,0,    1, 0, 1,0,0,2,   0);
        add("gl_w2",     1,0,0, 0,1,0,    1, 0, 1,0,0,2,   0);
        add("gl_w3",     1,0,0, 0,0,0,    1, 0, 1,0,0,2,   0);
        add("gl_w4",     1,0,0, 0,0,0,    1, 1, 0,1,0,2,   1);
        add("gl_post",   1,0,0, 0,0,0,    1, 1, 0,0,0,2,   1);
        add("ab_acc",    1,1,1, 0,0,0,    1, 1, 1,0,0,2,   0);
        add("ab_w1",     1,0,0, 1,0,0,    0, 0, 0,0,1,3,   1);
        add("ab_post",   1,0,0, 0,0,0,    0, 0, 0,0,0,3,   1);
        add("mr_acc",    1,1,2, 0,0,0,    2, 0, 1,0,0,3,   0);
        add("mr_rst",    0,0,0, 0,0,0,    0, 0, 0,0,0,0,   0);
        add("mr_rel",    1,0,0, 0,0,0,    0, 0, 0,0,0,0,   1);
        add("mr_quiet1", 1,0,0, 0,0,0,    0, 0, 0,0,0,0,   1);
        add("mr_quiet2", 1,0,0, 0,0,0,    0, 0, 0,0,0,0,   1);

        #1;
        foreach (vt[i]) begin
            step(vt[i].r, vt[i].v, vt[i].md, vt[i].ab,
                 vt[i].se, vt[i].sv);
            check(vt[i].name, {vt[i].mo, vt[i].cur, vt[i].bsy, vt[i].dn,
                               vt[i].er, vt[i].code, vt[i].rdy});
        end

        for (int c = 0; c < 3000; c++) begin
            bit r, v, ab, se;
            bit [1:0] md, sv;
            r  = ($urandom_range(0, 39) != 0);
            v  = ($urandom_range(0, 2) == 0);
            md = 2'($urandom_range(0, 3));
            ab = ($urandom_range(0, 11) == 0);
            se = ($urandom_range(0, 3) == 0);
            sv = 2'($urandom_range(0, 3));
            step(r, v, md, ab, se, sv);
            check("random", {m_drive, m_cur, m_inflight, m_done, m_err,
                             m_code, r && !m_inflight});
            tests++;
            if (done && err) begin
                fails++;
                $display("FAIL pulse_excl: done=%b err=%b want not both",
                         done, err);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
